// File: rtl/coin_bank_arbiter.sv
// Coin ledger for the tower-defense game: serialises kill/sell credits
// into one balance and arbitrates tower builds round-robin against it.
module coin_bank_arbiter #(
    parameter int MONS        = 16,
    parameter int TOWERS      = 8,
    parameter int COIN_W      = 16,
    parameter int INIT_COINS  = 100,
    parameter int KILL_REWARD = 10,
    parameter int SELL_REFUND = 20,
    parameter int BUILD_COST  = 30
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [MONS-1:0]   kill_pulse,
    input  logic [TOWERS-1:0] sell_pulse,
    input  logic [TOWERS-1:0] build_req,
    output logic [TOWERS-1:0] build_grant,
    output logic [TOWERS-1:0] build_deny,
    output logic [COIN_W-1:0] coins,
    output logic              busy,
    output logic              ev_drop
);

    localparam int PW = $clog2(TOWERS);
    localparam int SW = COIN_W + 2;
    localparam logic [SW-1:0] MAXC = {2'b00, {COIN_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        DECIDE,
        WAIT_DROP
    } state_t;

    state_t            state;
    logic [MONS-1:0]   kill_pend;
    logic [MONS-1:0]   kill_srv;
    logic [MONS-1:0]   kill_next;
    logic [TOWERS-1:0] sell_pend;
    logic [TOWERS-1:0] sell_srv;
    logic [TOWERS-1:0] sell_next;
    logic [SW-1:0]     credit;
    logic [SW-1:0]     debit;
    logic [SW-1:0]     sum;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     rr_next;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     idx;
    logic              drop_now;
    logic              do_grant;
    logic              sat;

    // Lowest set bit wins; sells outrank kills.
    assign sell_srv  = sell_pend & (~sell_pend + TOWERS'(1));
    assign kill_srv  = (|sell_pend) ? '0
                     : kill_pend & (~kill_pend + MONS'(1));
    assign sell_next = (sell_pend & ~sell_srv) | sell_pulse;
    assign kill_next = (kill_pend & ~kill_srv) | kill_pulse;

    assign drop_now = (|(sell_pulse & sell_pend & ~sell_srv))
                   || (|(kill_pulse & kill_pend & ~kill_srv));

    always_comb begin
        credit = '0;
        if (|sell_pend)
            credit = SW'(SELL_REFUND);
        else if (|kill_pend)
            credit = SW'(KILL_REWARD);
    end

    // Grant looks at the pre-update balance only.
    assign do_grant = (state == DECIDE) && build_req[sel]
                   && ({2'b00, coins} >= SW'(BUILD_COST));
    assign debit = do_grant ? SW'(BUILD_COST) : '0;
    assign sum   = {2'b00, coins} + credit - debit;
    assign sat   = sum > MAXC;
    assign busy  = (|kill_pend) | (|sell_pend);

    assign rr_next = (sel == PW'(TOWERS - 1)) ? '0 : sel + PW'(1);

    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = TOWERS - 1; i >= 0; i--) begin
            idx = PW'((int'(rr_ptr) + i) % TOWERS);
            if (build_req[idx])
                pick = idx;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state       <= IDLE;
            kill_pend   <= '0;
            sell_pend   <= '0;
            coins       <= COIN_W'(INIT_COINS);
            sel         <= '0;
            rr_ptr      <= '0;
            build_grant <= '0;
            build_deny  <= '0;
            ev_drop     <= 1'b0;
        end else begin
            kill_pend   <= kill_next;
            sell_pend   <= sell_next;
            coins       <= sat ? MAXC[COIN_W-1:0] : sum[COIN_W-1:0];
            build_grant <= '0;
            build_deny  <= '0;
            if (drop_now || sat)
                ev_drop <= 1'b1;
            unique case (state)
                IDLE: begin
                    if ((|build_req) && !busy) begin
                        sel   <= pick;
                        state <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (!build_req[sel]) begin
                        state <= IDLE;
                    end else begin
                        if (do_grant)
                            build_grant[sel] <= 1'b1;
                        else
                            build_deny[sel] <= 1'b1;
                        state <= WAIT_DROP;
                    end
                end
                WAIT_DROP: begin
                    if (!build_req[sel]) begin
                        rr_ptr <= rr_next;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_bank_arbiter.sv
// Bench for coin_bank_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural ledger model.
module tb_coin_bank_arbiter;

    logic        Clk;
    logic        Reset;
    logic [15:0] kill_pulse;
    logic [7:0]  sell_pulse;
    logic [7:0]  build_req;
    logic [7:0]  build_grant;
    logic [7:0]  build_deny;
    logic [15:0] coins;
    logic        busy;
    logic        ev_drop;

    logic        Reset2;
    logic [15:0] kill2;
    logic [7:0]  sell2;
    logic [7:0]  req2;
    logic [7:0]  grant2;
    logic [7:0]  deny2;
    logic [7:0]  coins2;
    logic        busy2;
    logic        drop2;

    int ncmp  = 0;
    int nfail = 0;

    coin_bank_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .kill_pulse(kill_pulse), .sell_pulse(sell_pulse),
        .build_req(build_req), .build_grant(build_grant),
        .build_deny(build_deny), .coins(coins),
        .busy(busy), .ev_drop(ev_drop)
    );

    coin_bank_arbiter #(.COIN_W(8)) dut8 (
        .Clk(Clk), .Reset(Reset2),
        .kill_pulse(kill2), .sell_pulse(sell2),
        .build_req(req2), .build_grant(grant2),
        .build_deny(deny2), .coins(coins2),
        .busy(busy2), .ev_drop(drop2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural ledger: pending events as flag arrays, balance as int.
    bit       mk[16];
    bit       ms[8];
    int       mbal  = 100;
    bit       mdrop = 0;
    string    mph   = "idle";
    int       msel  = 0;
    int       mrr   = 0;
    bit [7:0] mg    = 0;
    bit [7:0] md    = 0;

    function automatic bit m_busy();
        bit b = 0;
        foreach (mk[i]) b |= mk[i];
        foreach (ms[i]) b |= ms[i];
        return b;
    endfunction

    task automatic model_edge();
        int sidx = -1;
        int kidx = -1;
        int credit = 0;
        int debit = 0;
        bit bsy;
        mg = 0;
        md = 0;
        if (!Reset) begin
            foreach (mk[i]) mk[i] = 0;
            foreach (ms[i]) ms[i] = 0;
            mbal = 100; mdrop = 0; mph = "idle";
            msel = 0; mrr = 0;
            return;
        end
        bsy = m_busy();
        for (int i = 0; i < 8; i++)
            if (ms[i] && sidx < 0) sidx = i;
        if (sidx < 0)
            for (int i = 0; i < 16; i++)
                if (mk[i] && kidx < 0) kidx = i;
        if (sidx >= 0) credit = 20;
        else if (kidx >= 0) credit = 10;
        if (mph == "idle") begin
            if (build_req != 0 && !bsy) begin
                for (int k = 7; k >= 0; k--)
                    if (build_req[(mrr + k) % 8]) msel = (mrr + k) % 8;
                mph = "decide";
            end
        end else if (mph == "decide") begin
            if (!build_req[msel]) mph = "idle";
            else begin
                if (mbal >= 30) begin mg[msel] = 1; debit = 30; end
                else md[msel] = 1;
                mph = "wait";
            end
        end else begin
            if (!build_req[msel]) begin
                mrr = (msel + 1) % 8;
                mph = "idle";
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (sell_pulse[i] && ms[i] && i != sidx) mdrop = 1;
            ms[i] = (ms[i] && i != sidx) || sell_pulse[i];
        end
        for (int i = 0; i < 16; i++) begin
            if (kill_pulse[i] && mk[i] && i != kidx) mdrop = 1;
            mk[i] = (mk[i] && i != kidx) || kill_pulse[i];
        end
        mbal = mbal + credit - debit;
        if (mbal > 65535) begin mbal = 65535; mdrop = 1; end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_edge();
        #1;
        chk("coins", 32'(coins), 32'(mbal));
        chk("grant", 32'(build_grant), 32'(mg));
        chk("deny", 32'(build_deny), 32'(md));
        chk("busy", 32'(busy), 32'(m_busy()));
        chk("ev_drop", 32'(ev_drop), 32'(mdrop));
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        cyc();
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 0; kill_pulse = 0; sell_pulse = 0; build_req = 0;
        Reset2 = 0; kill2 = 0; sell2 = 0; req2 = 0;
        cyc();
        cyc();
        Reset = 1;
        repeat (20) cyc();
        chk("rst_coins", 32'(coins), 100);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(ev_drop), 0);
        chk("rst_grant", 32'(build_grant | build_deny), 0);

        // Two kills drain one per cycle.
        kill_pulse = 16'h0005;
        cyc();
        kill_pulse = 0;
        chk("k_busy1", 32'(busy), 1);
        chk("k_c0", 32'(coins), 100);
        cyc();
        chk("k_c1", 32'(coins), 110);
        chk("k_busy2", 32'(busy), 1);
        cyc();
        chk("k_c2", 32'(coins), 120);
        chk("k_busy3", 32'(busy), 0);

        // Sell is served before kill.
        do_reset();
        sell_pulse = 8'h08; kill_pulse = 16'h0001;
        cyc();
        sell_pulse = 0; kill_pulse = 0;
        cyc();
        chk("s_first", 32'(coins), 120);
        cyc();
        chk("s_then_k", 32'(coins), 130);

        // Round-robin builds from 100 coins.
        do_reset();
        build_req = 8'h11;
        cyc(); cyc();
        chk("g0", 32'(build_grant), 32'h01);
        chk("g0_coins", 32'(coins), 70);
        cyc();
        chk("g0_once", 32'(build_grant), 0);
        cyc();
        build_req = 8'h10;
        cyc(); cyc(); cyc();
        chk("g4", 32'(build_grant), 32'h10);
        chk("g4_coins", 32'(coins), 40);
        cyc(); cyc();
        build_req = 8'h21;
        cyc(); cyc(); cyc();
        chk("g5_rr", 32'(build_grant), 32'h20);
        chk("g5_coins", 32'(coins), 10);
        cyc(); cyc();
        build_req = 0;
        cyc();

        // Deny at 20 coins; a kill in DECIDE does not help.
        kill_pulse = 16'h0001;
        cyc();
        kill_pulse = 0;
        cyc();
        chk("d_c20", 32'(coins), 20);
        build_req = 8'h04; kill_pulse = 16'h0001;
        cyc();
        kill_pulse = 0;
        cyc();
        chk("d_deny", 32'(build_deny), 32'h04);
        chk("d_nogrant", 32'(build_grant), 0);
        chk("d_c30", 32'(coins), 30);
        cyc();
        chk("d_once", 32'(build_deny), 0);
        build_req = 0;
        cyc(); cyc();

        // 8-bit instance: saturation and reset in WAIT_DROP.
        Reset2 = 1;
        kill2 = 16'h7FFF;
        cyc();
        kill2 = 0;
        repeat (16) cyc();
        chk("n_250", 32'(coins2), 250);
        chk("n_drop0", 32'(drop2), 0);
        kill2 = 16'h0001;
        cyc();
        kill2 = 0;
        cyc(); cyc();
        chk("n_sat", 32'(coins2), 255);
        chk("n_drop1", 32'(drop2), 1);
        req2 = 8'h01;
        cyc(); cyc();
        chk("n_grant", 32'(grant2), 32'h01);
        chk("n_225", 32'(coins2), 225);
        cyc();
        Reset2 = 0;
        cyc();
        chk("n_rst_c", 32'(coins2), 100);
        chk("n_rst_d", 32'(drop2), 0);
        chk("n_rst_g", 32'(grant2), 0);
        Reset2 = 1;
        cyc();
        chk("n_idle", 32'(grant2), 0);
        cyc();
        chk("n_regrant", 32'(grant2), 32'h01);
        chk("n_70", 32'(coins2), 70);
        req2 = 0;

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            kill_pulse = ($urandom % 3 == 0)
                ? 16'($urandom & $urandom) : 16'h0;
            sell_pulse = ($urandom % 5 == 0)
                ? 8'($urandom & $urandom & $urandom) : 8'h0;
            for (int b = 0; b < 8; b++) begin
                if (build_req[b]) begin
                    if ($urandom % 4 == 0) build_req[b] = 1'b0;
                end else if ($urandom % 10 == 0) begin
                    build_req[b] = 1'b1;
                end
            end
            Reset = ($urandom % 200 != 0);
            cyc();
        end
        Reset = 1; kill_pulse = 0; sell_pulse = 0; build_req = 0;
        repeat (30) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
